// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port. Sub-word stores are done as read-modify-write.
// Every output comes straight from a register.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   i_req/i_addr                fetch request (read only)
//   i_rdata/i_ack               fetch result word and its completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_mask              data request; mask 00=byte, 01=half, 1x=word
//   d_rdata/d_ack               raw loaded word and its completion pulse
//   m_addr/m_wdata/m_we/m_re    memory command (m_addr is word aligned)
//   m_rdata                     memory read data, valid the cycle after m_re
//   busy                        high whenever the FSM is not in IDLE
//
// Build option
//   MEM_ARB_FAIR_EN  when defined, a tie goes to the port not granted last;
//                    otherwise the data port always wins a tie.
module mem_arbiter #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [1:0]    d_mask,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic          m_we,
  output logic          m_re,
  input  logic [31:0]   m_rdata,
  output logic          busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] MRG  = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] ACK  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          port_q, port_d;      // 1 = data port owns the transaction
  logic          we_q, we_d;
  logic          half_q, half_d;      // sub-word store size: 1 = half, 0 = byte
  logic [1:0]    lo_q, lo_d;          // byte lane of the granted address
  logic [15:0]   wdata_q, wdata_d;    // low store data kept for the merge
  logic [31:0]   rbuf_q, rbuf_d;      // readback word for read-modify-write
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic          m_we_q, m_we_d;
  logic          m_re_q, m_re_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          pick_d;              // arbitration result in IDLE
  logic [31:0]   merged_c;

`ifdef MEM_ARB_FAIR_EN
  logic          last_i_q, last_i_d;  // 1 = fetch port was granted last
`endif

  // Replace the addressed lane(s) of the readback word with the store data.
  always_comb begin
    merged_c = rbuf_q;
    if (half_q) begin
      if (lo_q[1]) merged_c[31:16] = wdata_q;
      else         merged_c[15:0]  = wdata_q;
    end else begin
      case (lo_q)
        2'd0:    merged_c[7:0]   = wdata_q[7:0];
        2'd1:    merged_c[15:8]  = wdata_q[7:0];
        2'd2:    merged_c[23:16] = wdata_q[7:0];
        default: merged_c[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    half_d    = half_q;
    lo_d      = lo_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    last_i_d  = last_i_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pick_d = d_req;
`ifdef MEM_ARB_FAIR_EN
          // On a tie, favour the port that lost last time.
          if (i_req && d_req) pick_d = last_i_q;
          last_i_d = ~pick_d;
`endif
          port_d = pick_d;
          if (pick_d) begin
            we_d     = d_we;
            half_d   = d_mask[0];
            lo_d     = d_addr[1:0];
            wdata_d  = d_wdata[15:0];
            m_addr_d = {d_addr[AW-1:2], 2'b00};
          end else begin
            we_d     = 1'b0;
            half_d   = 1'b0;
            lo_d     = i_addr[1:0];
            m_addr_d = {i_addr[AW-1:2], 2'b00};
          end
          // Word stores skip the readback entirely.
          if (pick_d && d_we && d_mask[1]) begin
            state_d   = WR;
            m_wdata_d = d_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        rbuf_d = m_rdata;
        if (!port_q)    i_rdata_d = m_rdata;
        else if (!we_q) d_rdata_d = m_rdata;
        // Only sub-word stores reach CAP with we set.
        state_d = we_q ? MRG : ACK;
      end
      MRG: begin
        m_wdata_d = merged_c;
        state_d   = WR;
      end
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and acks are decoded from the next state so they line up
    // with the state register.
    m_re_d  = (state_d == RD);
    m_we_d  = (state_d == WR);
    busy_d  = (state_d != IDLE);
    i_ack_d = (state_d == ACK) && !port_d;
    d_ack_d = (state_d == ACK) && port_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      half_q    <= 1'b0;
      lo_q      <= 2'd0;
      wdata_q   <= 16'd0;
      rbuf_q    <= 32'd0;
      m_addr_q  <= '0;
      m_wdata_q <= 32'd0;
      m_we_q    <= 1'b0;
      m_re_q    <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      busy_q    <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      last_i_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      half_q    <= half_d;
      lo_q      <= lo_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
      m_re_q    <= m_re_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
`ifdef MEM_ARB_FAIR_EN
      last_i_q  <= last_i_d;
`endif
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_ack   = d_ack_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_we    = m_we_q;
  assign m_re    = m_re_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, reference memory,
// and a scoreboard of expected acks popped as the DUT acknowledges.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_mask;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, d_ack, m_we, m_re, busy;

  mem_arbiter #(.AW(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mask(d_mask), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;      // 1 = data port
    logic        has_data;  // compare rdata (loads and fetches)
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          excl_viol = 0;
  int          we_total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Memory model: read data appears the cycle after m_re.
  always @(posedge clk) begin
    if (m_re) m_rdata <= mem[m_addr[11:2]];
    if (m_we) mem[m_addr[11:2]] <= m_wdata;
  end

  // Output monitor: pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (m_re && m_we) excl_viol++;
    if (i_ack && d_ack) excl_viol++;
    if (m_we) we_total++;
    if (i_ack || d_ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, i_ack, d_ack}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("ack_port", {31'd0, d_ack}, {31'd0, sb_e.port});
        if (sb_e.has_data)
          check("ack_rdata", sb_e.port ? d_rdata : i_rdata, sb_e.rdata);
      end
    end
  end

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] lo,
                                            input logic half, input logic [31:0] w);
    logic [31:0] msk;
    int          sh;
    sh  = half ? (lo[1] ? 16 : 0) : 8 * int'(lo);
    msk = (half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    return (old & ~msk) | ((w << sh) & msk);
  endfunction

  // One transaction on one port with timing checks relative to grant cycle t.
  task automatic xact(input logic is_d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] mask, input string tag);
    int          widx;
    logic [31:0] old, nw, seen_wdata, seen_addr;
    int          exp_ack, exp_re, exp_we, ack_n, re_n, we_n, re_cnt, we_cnt;
    exp_t        e;
    widx = int'(addr[11:2]);
    old  = ref_mem[widx];
    nw   = old;
    if (!we) begin
      exp_ack = 3; exp_re = 1; exp_we = -1;
    end else if (mask[1]) begin
      exp_ack = 2; exp_re = -1; exp_we = 1; nw = wdata;
    end else begin
      exp_ack = 5; exp_re = 1; exp_we = 4; nw = ref_merge(old, addr[1:0], mask[0], wdata);
    end
    e.port = is_d; e.has_data = !we; e.rdata = old;
    @(posedge clk); #1;
    sb_q.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_mask = mask;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    ack_n = -1; re_n = -1; we_n = -1; re_cnt = 0; we_cnt = 0;
    seen_wdata = 32'd0; seen_addr = 32'd0;
    @(negedge clk);  // cycle t
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (m_re) begin re_cnt++; re_n = n; seen_addr = m_addr; end
      if (m_we) begin we_cnt++; we_n = n; seen_wdata = m_wdata; seen_addr = m_addr; end
      if (is_d ? d_ack : i_ack) begin
        ack_n = n;
        check({tag, "_busy_at_ack"}, {31'd0, busy}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    if (ack_n < 0) begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_ack_cycle"}, ack_n, exp_ack);
      check({tag, "_re_cycle"}, re_n, exp_re);
      check({tag, "_we_cycle"}, we_n, exp_we);
      check({tag, "_re_cnt"}, re_cnt, (exp_re < 0) ? 0 : 1);
      check({tag, "_we_cnt"}, we_cnt, (exp_we < 0) ? 0 : 1);
      check({tag, "_m_addr"}, seen_addr, {addr[31:2], 2'b00});
      if (we) check({tag, "_m_wdata"}, seen_wdata, nw);
    end
    ref_mem[widx] = nw;
    @(negedge clk);  // cycle t+ack+1
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  initial begin
    int          acks, bad, we_before;
    logic [31:0] ra, rw;
    logic [1:0]  rm;
    logic        rd, rwe;
    exp_t        e;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_mask = 2'b00;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) set_word(i, 32'h9E37_79B9 * i + 32'h1357);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("rst_strobes", {30'd0, m_re, m_we}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    #1 reset = 1'b0;

    // Directed examples.
    set_word(32'h100 >> 2, 32'hDEAD_BEEF);
    xact(1'b0, 1'b0, 32'h100, 32'd0, 2'b00, "fetch");
    check("fetch_i_rdata", i_rdata, 32'hDEAD_BEEF);
    set_word(32'h200 >> 2, 32'h1122_3344);
    xact(1'b1, 1'b1, 32'h203, 32'h0000_00AB, 2'b00, "byte_st");
    check("byte_st_mem", mem[32'h200 >> 2], 32'hAB22_3344);
    set_word(32'h200 >> 2, 32'h1122_3344);
    xact(1'b1, 1'b1, 32'h202, 32'h0000_BEEF, 2'b01, "half_st");
    check("half_st_mem", mem[32'h200 >> 2], 32'hBEEF_3344);
    xact(1'b1, 1'b1, 32'h208, 32'hCAFE_F00D, 2'b10, "word_st");
    check("word_st_mem", mem[32'h208 >> 2], 32'hCAFE_F00D);
    xact(1'b1, 1'b0, 32'h208, 32'd0, 2'b10, "load");
    check("load_d_rdata", d_rdata, 32'hCAFE_F00D);
    xact(1'b1, 1'b1, 32'h20C, 32'h0000_5A5A, 2'b01, "half_lo");
    xact(1'b1, 1'b1, 32'h210, 32'h0000_00C3, 2'b00, "byte_l0");

    // Mixed random traffic over a small window.
    for (int k = 0; k < 14; k++) begin
      ra  = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      rw  = $urandom;
      rm  = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      rwe = rd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!rd) ra[1:0] = 2'b00;
      xact(rd, rwe, ra, rw, rm, "rand");
    end

    // Both ports requesting continuously for four grants.
    do_reset();
    set_word(32'h500 >> 2, 32'h1111_0000);
    set_word(32'h504 >> 2, 32'h2222_0000);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FAIR_EN
      e.port = 1'(k % 2);
`else
      e.port = 1'b1;
`endif
      e.has_data = 1'b1;
      e.rdata = e.port ? 32'h2222_0000 : 32'h1111_0000;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h504; d_mask = 2'b10;
    acks = 0;
    for (int n = 0; n < 60 && acks < 4; n++) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    check("tie_ack_count", acks, 4);
    repeat (6) @(negedge clk);

    // Reset while a byte store sits in MRG.
    set_word(32'h300 >> 2, 32'h5566_7788);
    we_before = we_total;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h303; d_wdata = 32'h0000_00EE; d_mask = 2'b00;
    repeat (4) @(negedge clk);  // cycles t .. t+3
    check("abort_busy_mrg", {31'd0, busy}, 32'd1);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_strobes", {29'd0, d_ack, m_we, m_re}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_write", we_total - we_before, 32'd0);
    check("abort_mem", mem[32'h300 >> 2], 32'h5566_7788);

    // Final consistency.
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_vs_ref", bad, 0);
    check("sb_drained", sb_q.size(), 0);
    check("re_we_ack_excl", excl_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
